// File: rtl/game_countdown_timer.sv
// rtl/game_countdown_timer.sv - two-digit BCD countdown timer with pause/resume and expiry flag
module game_countdown_timer #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int WARN_THRESHOLD  = 10
) (
    input  logic       ClockIn,
    input  logic       Reset,
    input  logic       Load,
    input  logic [3:0] LoadTens,
    input  logic [3:0] LoadOnes,
    input  logic       Start,
    input  logic       Pause,
    output logic [3:0] OnesValue,
    output logic [3:0] TensValue,
    output logic       Running,
    output logic       TimeUp,
    output logic       Expired,
    output logic       Warning
);

    localparam int PW = (CLOCK_FREQUENCY > 1) ? $clog2(CLOCK_FREQUENCY) : 1;
    localparam logic [PW-1:0] PRESCALE_MAX = PW'(CLOCK_FREQUENCY - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t        state, state_next;
    logic [3:0]    ones, ones_next;
    logic [3:0]    tens, tens_next;
    logic [PW-1:0] prescaler, prescaler_next;
    logic          expired_q, expired_next;
    logic [7:0]    count_dec;

    function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    always_comb begin
        state_next     = state;
        ones_next      = ones;
        tens_next      = tens;
        prescaler_next = prescaler;
        expired_next   = 1'b0;

        if (Load) begin
            state_next     = IDLE;
            ones_next      = clamp_bcd(LoadOnes);
            tens_next      = clamp_bcd(LoadTens);
            prescaler_next = PRESCALE_MAX;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Start && ((ones != 4'd0) || (tens != 4'd0)))
                        state_next = RUNNING;
                end
                RUNNING: begin
                    // Pause wins over a same-cycle tick; the prescaler then holds at 0
                    if (Pause) begin
                        state_next = PAUSED;
                    end else if (prescaler == '0) begin
                        prescaler_next = PRESCALE_MAX;
                        if (ones != 4'd0) begin
                            ones_next = ones - 4'd1;
                        end else if (tens != 4'd0) begin
                            ones_next = 4'd9;
                            tens_next = tens - 4'd1;
                        end
                        if ((tens == 4'd0) && (ones <= 4'd1)) begin
                            state_next   = EXPIRED;
                            expired_next = (ones == 4'd1);
                        end
                    end else begin
                        prescaler_next = prescaler - 1'b1;
                    end
                end
                PAUSED: begin
                    if (Start)
                        state_next = RUNNING;
                end
                EXPIRED: begin
                    state_next = EXPIRED;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge ClockIn or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            ones      <= 4'd0;
            tens      <= 4'd0;
            prescaler <= PRESCALE_MAX;
            expired_q <= 1'b0;
        end else begin
            state     <= state_next;
            ones      <= ones_next;
            tens      <= tens_next;
            prescaler <= prescaler_next;
            expired_q <= expired_next;
        end
    end

    assign count_dec = ({4'd0, tens} * 8'd10) + {4'd0, ones};

    assign OnesValue = ones;
    assign TensValue = tens;
    assign Running   = (state == RUNNING);
    assign TimeUp    = (state == EXPIRED);
    assign Expired   = expired_q;
    assign Warning   = Running && (int'(count_dec) <= WARN_THRESHOLD);

endmodule

// File: tb/tb_game_countdown_timer.sv
// tb/tb_game_countdown_timer.sv - scoreboard bench for game_countdown_timer
module tb_game_countdown_timer;

    localparam int CF   = 4;
    localparam int WARN = 10;

    logic       ClockIn;
    logic       Reset;
    logic       Load;
    logic [3:0] LoadTens;
    logic [3:0] LoadOnes;
    logic       Start;
    logic       Pause;
    logic [3:0] OnesValue;
    logic [3:0] TensValue;
    logic       Running;
    logic       TimeUp;
    logic       Expired;
    logic       Warning;

    game_countdown_timer #(
        .CLOCK_FREQUENCY(CF),
        .WARN_THRESHOLD (WARN)
    ) dut (
        .ClockIn  (ClockIn),
        .Reset    (Reset),
        .Load     (Load),
        .LoadTens (LoadTens),
        .LoadOnes (LoadOnes),
        .Start    (Start),
        .Pause    (Pause),
        .OnesValue(OnesValue),
        .TensValue(TensValue),
        .Running  (Running),
        .TimeUp   (TimeUp),
        .Expired  (Expired),
        .Warning  (Warning)
    );

    typedef struct {
        int          at;
        string       name;
        logic [11:0] v;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    initial begin
        ClockIn = 1'b0;
        forever #5 ClockIn = ~ClockIn;
    end

    always @(posedge ClockIn) cyc <= cyc + 1;

    // expected vector: {tens, ones, running, timeup, expired, warning}
    function automatic void chk(input int at, input string nm, input int val,
                                input bit run, input bit tup, input bit ex);
        exp_t e;
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(val / 10);
        o = 4'(val % 10);
        e.at   = at;
        e.name = nm;
        e.v    = {t, o, run, tup, ex, (run && (val <= WARN))};
        q.push_back(e);
    endfunction

    always @(negedge ClockIn) begin
        logic [11:0] act;
        act = {TensValue, OnesValue, Running, TimeUp, Expired, Warning};
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].at == cyc) begin
                checks++;
                if (act !== q[i].v) begin
                    errors++;
                    $display("FAIL %s @cyc %0d: got %h%h r%b u%b e%b w%b, want %h%h r%b u%b e%b w%b",
                             q[i].name, cyc, act[11:8], act[7:4], act[3], act[2], act[1], act[0],
                             q[i].v[11:8], q[i].v[7:4], q[i].v[3], q[i].v[2], q[i].v[1], q[i].v[0]);
                end
                q.delete(i);
            end else if (q[i].at < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: expectation for cyc %0d never sampled (now %0d)", q[i].name, q[i].at, cyc);
                q.delete(i);
            end
        end
    end

    task automatic slot();
        @(posedge ClockIn);
        #1;
    endtask

    task automatic pulse(input bit l, input logic [3:0] lt, input logic [3:0] lo,
                         input bit s, input bit p);
        Load = l; LoadTens = lt; LoadOnes = lo; Start = s; Pause = p;
        slot();
        Load = 0; Start = 0; Pause = 0;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) slot();
    endtask

    int k;
    int k2;

    initial begin
        Reset = 0; Load = 0; LoadTens = 0; LoadOnes = 0; Start = 0; Pause = 0;
        slot();
        chk(cyc, "reset_state", 0, 0, 0, 0);
        slot();
        Reset = 1;
        slot();

        // 1: borrow across digits
        pulse(1, 4'd2, 4'd5, 0, 0);
        chk(cyc, "s1_load", 25, 0, 0, 0);
        pulse(0, 0, 0, 1, 0);
        k = cyc;
        for (int t = 0; t <= 7; t++) chk(k + 4 * t, $sformatf("s1_tick%0d", t), 25 - t, 1, 0, 0);
        chk(k + 3, "s1_pre_tick1", 25, 1, 0, 0);
        chk(k + 23, "s1_pre_borrow", 20, 1, 0, 0);
        chk(k + 27, "s1_pre_tick7", 19, 1, 0, 0);
        wait_to(k + 28);

        // 2: expiry
        pulse(1, 4'd0, 4'd2, 0, 0);
        pulse(0, 0, 0, 1, 0);
        k = cyc;
        chk(k,     "s2_start", 2, 1, 0, 0);
        chk(k + 3, "s2_pre01", 2, 1, 0, 0);
        chk(k + 4, "s2_01",    1, 1, 0, 0);
        chk(k + 7, "s2_pre00", 1, 1, 0, 0);
        chk(k + 8, "s2_expire", 0, 0, 1, 1);
        chk(k + 9, "s2_pulse_end", 0, 0, 1, 0);
        wait_to(k + 9);
        pulse(0, 0, 0, 1, 0);
        k2 = cyc;
        for (int i = 0; i < 9; i++) chk(k2 + i, $sformatf("s2_restart%0d", i), 0, 0, 1, 0);
        wait_to(k2 + 8);
        pulse(1, 4'd3, 4'd0, 0, 0);
        chk(cyc, "s2_reload", 30, 0, 0, 0);

        // 3: pause and resume
        pulse(1, 4'd1, 4'd0, 0, 0);
        pulse(0, 0, 0, 1, 0);
        k = cyc;
        chk(k,      "s3_warn_run", 10, 1, 0, 0);
        chk(k + 1,  "s3_warn_run2", 10, 1, 0, 0);
        chk(k + 2,  "s3_paused", 10, 0, 0, 0);
        chk(k + 10, "s3_paused_end", 10, 0, 0, 0);
        chk(k + 11, "s3_resumed", 10, 1, 0, 0);
        chk(k + 13, "s3_pre09", 10, 1, 0, 0);
        chk(k + 14, "s3_09", 9, 1, 0, 0);
        slot();
        Pause = 1;
        repeat (9) slot();
        Pause = 0; Start = 1;
        slot();
        Start = 0;
        wait_to(k + 14);

        // 4: clamp and priority
        pulse(1, 4'hF, 4'hC, 0, 0);
        chk(cyc, "s4_clamp", 99, 0, 0, 0);
        pulse(1, 4'd4, 4'd7, 1, 0);
        k = cyc;
        chk(k,     "s4_load_beats_start", 47, 0, 0, 0);
        chk(k + 2, "s4_load_beats_start2", 47, 0, 0, 0);
        wait_to(k + 2);
        pulse(0, 0, 0, 1, 0);
        chk(cyc, "s4_run47", 47, 1, 0, 0);
        pulse(0, 0, 0, 1, 1);
        k = cyc;
        chk(k,     "s4_pause_beats_start", 47, 0, 0, 0);
        chk(k + 3, "s4_pause_hold", 47, 0, 0, 0);
        wait_to(k + 3);
        pulse(1, 4'd5, 4'd8, 0, 0);
        pulse(0, 0, 0, 1, 0);
        k = cyc;
        chk(k + 4, "s4_57", 57, 1, 0, 0);
        chk(k + 7, "s4_57_last", 57, 1, 0, 0);
        wait_to(k + 7);
        Load = 1; LoadTens = 4'd6; LoadOnes = 4'd1;
        slot();
        Load = 0;
        chk(cyc, "s4_load_beats_tick", 61, 0, 0, 0);
        pulse(0, 0, 0, 1, 0);
        k = cyc;
        chk(k + 3, "s4_reload_hold", 61, 1, 0, 0);
        chk(k + 4, "s4_reload_tick", 60, 1, 0, 0);
        wait_to(k + 4);

        // 5: zero start
        pulse(1, 4'd0, 4'd0, 0, 0);
        pulse(0, 0, 0, 1, 0);
        k = cyc;
        for (int i = 0; i < 7; i++) chk(k + i, $sformatf("s5_zero%0d", i), 0, 0, 0, 0);
        wait_to(k + 6);

        // 6: asynchronous reset mid-run
        pulse(1, 4'd4, 4'd2, 0, 0);
        pulse(0, 0, 0, 1, 0);
        k = cyc;
        chk(k, "s6_run42", 42, 1, 0, 0);
        slot();
        #1;
        Reset = 0;
        chk(k + 1, "s6_async_reset", 0, 0, 0, 0);
        slot();
        chk(k + 2, "s6_reset_hold", 0, 0, 0, 0);
        Reset = 1;
        slot();
        pulse(0, 0, 0, 1, 0);
        k = cyc;
        for (int i = 0; i < 5; i++) chk(k + i, $sformatf("s6_zero_start%0d", i), 0, 0, 0, 0);

        for (int i = 0; i < 200 && q.size() > 0; i++) slot();
        if (q.size() > 0) begin
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", q.size());
            errors += q.size();
            checks += q.size();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
